divide_pipelined: RTL and testbench

//  Parametrised, fully pipelined unsigned restoring divider with valid/ready handshake and tag sideband.

---
 rtl/divide_pipelined_pkg.sv | 27 ++
 rtl/divide_pipelined_if.sv | 41 ++++
 rtl/divide_pipelined_stage.sv | 23 ++
 rtl/divide_pipelined.sv | 135 +++++++++++++
 tb/tb_divide_pipelined.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/divide_pipelined_pkg.sv
// divide_pipelined_pkg: shared widths and the per-stage pipeline record of the
// pipelined restoring divider.
// Contents:
//   DP_NUMER_W / DP_DENOM_W / DP_QUOT_W / DP_TAG_W  default widths
//   stage_t  one pipeline stage: valid, operands, partial remainder r,
//            partial quotient q, sideband tag and the two early flags.
// stage_t is sized from these localparams, so a build with other widths
// changes them here rather than only overriding the top-level parameters.
package divide_pipelined_pkg;

    localparam int DP_NUMER_W = 23;
    localparam int DP_DENOM_W = 15;
    localparam int DP_QUOT_W  = 11;
    localparam int DP_TAG_W   = 8;

    typedef struct packed {
        logic                  valid;
        logic [DP_NUMER_W-1:0] numer;
        logic [DP_DENOM_W-1:0] denom;
        logic [DP_DENOM_W:0]   r;
        logic [DP_QUOT_W-1:0]  q;
        logic [DP_TAG_W-1:0]   tag;
        logic                  div_zero;
        logic                  overflow;
    } stage_t;

endpackage

// File: rtl/divide_pipelined_if.sv
// divide_pipelined_if: valid/ready request and result channels of the divider.
// Signals:
//   in_valid/in_ready, numer, denom, in_tag          request channel
//   out_valid/out_ready, quotient, remainder, out_tag,
//   div_zero, overflow                               result channel
//   busy                                             any stage occupied
// Modports: master (producer/consumer side), slave (the divider).
interface divide_pipelined_if
    import divide_pipelined_pkg::*;
#(
    parameter int NUMER_W = DP_NUMER_W,
    parameter int DENOM_W = DP_DENOM_W,
    parameter int QUOT_W  = DP_QUOT_W,
    parameter int TAG_W   = DP_TAG_W
);
    logic               in_valid;
    logic               in_ready;
    logic [NUMER_W-1:0] numer;
    logic [DENOM_W-1:0] denom;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [QUOT_W-1:0]  quotient;
    logic [DENOM_W-1:0] remainder;
    logic [TAG_W-1:0]   out_tag;
    logic               div_zero;
    logic               overflow;
    logic               busy;

    modport master (
        output in_valid, numer, denom, in_tag, out_ready,
        input  in_ready, out_valid, quotient, remainder, out_tag,
               div_zero, overflow, busy
    );

    modport slave (
        input  in_valid, numer, denom, in_tag, out_ready,
        output in_ready, out_valid, quotient, remainder, out_tag,
               div_zero, overflow, busy
    );
endinterface

// File: rtl/divide_pipelined_stage.sv
// divide_stage: one combinational restoring-division step.
// Ports:
//   r_in      in  DENOM_W+1  partial remainder from the previous stage
//   numer_bit in  1          next dividend bit, MSB first
//   denom     in  DENOM_W    divisor
//   r_out     out DENOM_W+1  partial remainder after the trial subtraction
//   q_bit     out 1          quotient bit produced by this step
module divide_stage #(
    parameter int DENOM_W = 15
) (
    input  logic [DENOM_W:0]   r_in,
    input  logic               numer_bit,
    input  logic [DENOM_W-1:0] denom,
    output logic [DENOM_W:0]   r_out,
    output logic               q_bit
);
    // One bit wider than r so the shift never drops a set MSB.
    logic [DENOM_W+1:0] r_shift;

    assign r_shift = {r_in, numer_bit};
    assign q_bit   = (r_shift >= {2'b00, denom});
    assign r_out   = (DENOM_W+1)'(q_bit ? (r_shift - {2'b00, denom}) : r_shift);
endmodule

// File: rtl/divide_pipelined.sv
// divide_pipelined: fully pipelined unsigned restoring divider, one division
// per cycle, QUOT_W+2 cycles latency, global stall for backpressure.
// Ports:
//   clock   rising-edge clock
//   sclr_n  synchronous reset, active-low (clears valids and all outputs)
//   bus     divide_pipelined_if.slave: in_valid/in_ready/numer/denom/in_tag,
//           out_valid/out_ready/quotient/remainder/out_tag/div_zero/overflow,
//           busy
// Optional feature: define DIVIDE_PIPELINED_ROUND_EN to round the quotient
// half-up (remainder stays truncated); latency is unchanged.
module divide_pipelined
    import divide_pipelined_pkg::*;
#(
    parameter int NUMER_W = DP_NUMER_W,
    parameter int DENOM_W = DP_DENOM_W,
    parameter int QUOT_W  = DP_QUOT_W,
    parameter int TAG_W   = DP_TAG_W
) (
    input  logic              clock,
    input  logic              sclr_n,
    divide_pipelined_if.slave bus
);
    localparam int CMP_W = (NUMER_W > DENOM_W) ? NUMER_W : DENOM_W;

    stage_t             st     [0:QUOT_W];
    logic [DENOM_W:0]   step_r [1:QUOT_W];
    logic               step_q [1:QUOT_W];
    logic               adv;
    logic               any_stage_valid;
    logic [QUOT_W-1:0]  res_q;
    logic [DENOM_W-1:0] res_r;
    logic               res_ovf;

`ifdef DIVIDE_PIPELINED_ROUND_EN
    function automatic logic round_half_up(input logic [DENOM_W:0]   r,
                                           input logic [DENOM_W-1:0] d);
        return ({r, 1'b0} >= {2'b00, d});
    endfunction
`endif

    // Stall freezes every stage, bubbles included.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 1; k <= QUOT_W; k++) begin : g_step
        divide_stage #(.DENOM_W(DENOM_W)) u_stage (
            .r_in      (st[k-1].r),
            .numer_bit (st[k-1].numer[QUOT_W-k]),
            .denom     (st[k-1].denom),
            .r_out     (step_r[k]),
            .q_bit     (step_q[k])
        );
    end

    // Stage 0 input register, then one restoring step per stage. The whole
    // record is forwarded and only r and the new quotient bit are replaced.
    always_ff @(posedge clock) begin
        if (adv) begin
            st[0].valid    <= bus.in_valid;
            st[0].numer    <= bus.numer;
            st[0].denom    <= bus.denom;
            st[0].tag      <= bus.in_tag;
            st[0].div_zero <= (bus.denom == '0);
            st[0].overflow <= (CMP_W'(bus.numer >> QUOT_W) >= CMP_W'(bus.denom));
            // Only meaningful when overflow is clear, where it fits in DENOM_W bits.
            st[0].r        <= (DENOM_W+1)'(bus.numer >> QUOT_W);
            st[0].q        <= '0;
            for (int k = 1; k <= QUOT_W; k++) begin
                st[k]             <= st[k-1];
                st[k].r           <= step_r[k];
                st[k].q[QUOT_W-k] <= step_q[k];
            end
        end
        if (!sclr_n) begin
            for (int k = 0; k <= QUOT_W; k++) begin
                st[k].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        res_q   = st[QUOT_W].q;
        res_r   = st[QUOT_W].r[DENOM_W-1:0];
        res_ovf = 1'b0;
        if (st[QUOT_W].div_zero) begin
            res_q = '1;
            res_r = '0;
        end else if (st[QUOT_W].overflow) begin
            res_q   = '1;
            res_r   = '0;
            res_ovf = 1'b1;
        end else begin
`ifdef DIVIDE_PIPELINED_ROUND_EN
            if (round_half_up(st[QUOT_W].r, st[QUOT_W].denom)) begin
                if (&st[QUOT_W].q) begin
                    res_ovf = 1'b1;
                end else begin
                    res_q = st[QUOT_W].q + QUOT_W'(1);
                end
            end
`endif
        end
    end

    // Output register; data only loads with a real result so bubbles leave
    // the last result (or the reset zeros) in place.
    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.out_tag   <= '0;
            bus.div_zero  <= 1'b0;
            bus.overflow  <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= st[QUOT_W].valid;
            if (st[QUOT_W].valid) begin
                bus.quotient  <= res_q;
                bus.remainder <= res_r;
                bus.out_tag   <= st[QUOT_W].tag;
                bus.div_zero  <= st[QUOT_W].div_zero;
                bus.overflow  <= res_ovf;
            end
        end
    end

    always_comb begin
        any_stage_valid = 1'b0;
        for (int k = 0; k <= QUOT_W; k++) begin
            any_stage_valid = any_stage_valid | st[k].valid;
        end
    end

    assign bus.busy = any_stage_valid || bus.out_valid;
endmodule

// File: tb/tb_divide_pipelined.sv
// tb_divide_pipelined: directed and random stimulus for divide_pipelined,
// checked against an arithmetic reference model (n / d, n % d with the
// saturation, flag and optional rounding rules) through a FIFO scoreboard.
module tb_divide_pipelined;
    import divide_pipelined_pkg::*;

    localparam int NW  = DP_NUMER_W;
    localparam int DW  = DP_DENOM_W;
    localparam int QW  = DP_QUOT_W;
    localparam int TW  = DP_TAG_W;
    localparam int LAT = QW + 2;
    localparam int unsigned QMAX = (1 << QW) - 1;
`ifdef DIVIDE_PIPELINED_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        logic [QW-1:0] q;
        logic [DW-1:0] r;
        logic [TW-1:0] tag;
        logic          dz;
        logic          ov;
        int            t_in;
    } exp_t;

    logic clock  = 1'b0;
    logic sclr_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    bit   check_lat = 1'b0;
    bit   xfer      = 1'b0;
    exp_t expq[$];
    logic [QW-1:0] last_q;
    logic [DW-1:0] last_r;
    logic          last_dz;
    logic          last_ov;

    always #5 clock = ~clock;

    divide_pipelined_if #(.NUMER_W(NW), .DENOM_W(DW), .QUOT_W(QW), .TAG_W(TW)) bus ();

    divide_pipelined #(.NUMER_W(NW), .DENOM_W(DW), .QUOT_W(QW), .TAG_W(TW)) dut (
        .clock  (clock),
        .sclr_n (sclr_n),
        .bus    (bus)
    );

    function automatic exp_t model(input int unsigned n, input int unsigned d,
                                   input logic [TW-1:0] tag, input int t);
        exp_t e;
        int unsigned qt;
        int unsigned rt;
        e.tag = tag; e.t_in = t; e.dz = 1'b0; e.ov = 1'b0; e.q = '1; e.r = '0;
        if (d == 0) begin
            e.dz = 1'b1;
        end else begin
            qt = n / d;
            rt = n % d;
            if (qt > QMAX) begin
                e.ov = 1'b1;
            end else begin
                e.q = QW'(qt);
                e.r = DW'(rt);
                if (ROUND && (2 * rt >= d)) begin
                    if (qt == QMAX) e.ov = 1'b1;
                    else            e.q  = QW'(qt + 1);
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int unsigned n, input int unsigned d, input logic [TW-1:0] tag);
        bus.in_valid = 1'b1;
        bus.numer    = NW'(n);
        bus.denom    = DW'(d);
        bus.in_tag   = tag;
    endtask

    task automatic rand_in();
        int unsigned d;
        int unsigned n;
        int unsigned lim;
        case ($urandom_range(0, 9))
            0:       d = 0;
            1, 2:    d = $urandom_range(1, 50);
            default: d = $urandom_range(1, (1 << DW) - 1);
        endcase
        if (d == 0 || $urandom_range(0, 4) == 0) begin
            n = $urandom_range(0, (1 << NW) - 1);
        end else begin
            lim = d * (QMAX + 1) - 1;
            if (lim > (1 << NW) - 1) lim = (1 << NW) - 1;
            n = $urandom_range(0, lim);
        end
        set_in(n, d, TW'($urandom));
    endtask

    // Sample handshakes at the falling edge, then advance one rising edge.
    task automatic tick();
        exp_t e;
        xfer = 1'b0;
        @(negedge clock);
        if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_out", 64'(bus.out_valid), 64'(0));
            end else begin
                e = expq.pop_front();
                chk("quotient",  64'(bus.quotient),  64'(e.q));
                chk("remainder", 64'(bus.remainder), 64'(e.r));
                chk("out_tag",   64'(bus.out_tag),   64'(e.tag));
                chk("div_zero",  64'(bus.div_zero),  64'(e.dz));
                chk("overflow",  64'(bus.overflow),  64'(e.ov));
                if (check_lat) chk("latency", 64'(cyc - e.t_in), 64'(LAT));
                last_q = bus.quotient; last_r = bus.remainder;
                last_dz = bus.div_zero; last_ov = bus.overflow;
                n_out++;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            expq.push_back(model(32'(bus.numer), 32'(bus.denom), bus.in_tag, cyc));
            xfer = 1'b1;
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && expq.size() != 0; i++) tick();
        chk("drain_left", 64'(expq.size()), 64'(0));
    endtask

    initial begin
        logic [QW-1:0] snap_q;
        logic [DW-1:0] snap_r;
        logic [TW-1:0] snap_tag;
        int            n0;
        int            stale;

        bus.in_valid = 1'b0; bus.numer = '0; bus.denom = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        sclr_n = 1'b0;
        tick(); tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_quotient",  64'(bus.quotient),  64'(0));
        chk("rst_remainder", 64'(bus.remainder), 64'(0));
        chk("rst_out_tag",   64'(bus.out_tag),   64'(0));
        chk("rst_div_zero",  64'(bus.div_zero),  64'(0));
        chk("rst_overflow",  64'(bus.overflow),  64'(0));
        chk("rst_busy",      64'(bus.busy),      64'(0));
        chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
        sclr_n = 1'b1;
        check_lat = 1'b1;

        // 1000 / 7
        set_in(1000, 7, 8'h11); tick(); bus.in_valid = 1'b0;
        chk("t1_busy", 64'(bus.busy), 64'(1));
        drain(40);
        chk("t1_quotient",  64'(last_q),  64'(ROUND ? 143 : 142));
        chk("t1_remainder", 64'(last_r),  64'(6));
        chk("t1_flags",     64'({last_dz, last_ov}), 64'(0));

        // 5000000 / 100 overflows
        set_in(5000000, 100, 8'h22); tick(); bus.in_valid = 1'b0; drain(40);
        chk("t2_quotient",  64'(last_q), 64'(2047));
        chk("t2_remainder", 64'(last_r), 64'(0));
        chk("t2_overflow",  64'(last_ov), 64'(1));
        chk("t2_div_zero",  64'(last_dz), 64'(0));

        // 123 / 0
        set_in(123, 0, 8'h33); tick(); bus.in_valid = 1'b0; drain(40);
        chk("t3_quotient",  64'(last_q),  64'(2047));
        chk("t3_remainder", 64'(last_r),  64'(0));
        chk("t3_div_zero",  64'(last_dz), 64'(1));
        chk("t3_overflow",  64'(last_ov), 64'(0));

        // 4095 / 2: largest in-range quotient
        set_in(4095, 2, 8'h44); tick(); bus.in_valid = 1'b0; drain(40);
        chk("t4_quotient",  64'(last_q),  64'(2047));
        chk("t4_remainder", 64'(last_r),  64'(1));
        chk("t4_overflow",  64'(last_ov), 64'(ROUND ? 1 : 0));
        chk("t4_idle_busy", 64'(bus.busy), 64'(0));

        // 20 back-to-back random divisions
        n0 = n_out;
        for (int i = 0; i < 20; i++) begin
            rand_in();
            tick();
        end
        bus.in_valid = 1'b0;
        drain(40);
        chk("t5_count", 64'(n_out - n0), 64'(20));

        // Stream, then hold the output for 5 cycles
        check_lat = 1'b0;
        rand_in();
        for (int i = 0; i < 30 && !bus.out_valid; i++) begin
            tick();
            if (xfer) rand_in();
        end
        chk("t6_first_valid", 64'(bus.out_valid), 64'(1));
        bus.out_ready = 1'b0;
        snap_q = bus.quotient; snap_r = bus.remainder; snap_tag = bus.out_tag;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (xfer) rand_in();
            chk("hold_in_ready",  64'(bus.in_ready),  64'(0));
            chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
            chk("hold_quotient",  64'(bus.quotient),  64'(snap_q));
            chk("hold_remainder", 64'(bus.remainder), 64'(snap_r));
            chk("hold_out_tag",   64'(bus.out_tag),   64'(snap_tag));
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (xfer) rand_in();
        end
        bus.in_valid = 1'b0;
        drain(60);

        // Reset with 4 entries in flight
        for (int i = 0; i < 4; i++) begin
            rand_in();
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", 64'(bus.busy), 64'(1));
        sclr_n = 1'b0;
        tick();
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_busy",      64'(bus.busy),      64'(0));
        chk("mid_rst_quotient",  64'(bus.quotient),  64'(0));
        expq.delete();
        sclr_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) stale++;
        end
        chk("no_stale", 64'(stale), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
